// File: rtl/dram_ctrl.sv
// Single-request DRAM pin sequencer (ACT/RD/WR/PRE); closed-page by default, open-page with DRAM_CTRL_OPEN_PAGE_EN.
// Latency: T_RCD+read/T_WR (+T_RP closed-page) cycles; req_ready only in IDLE, one request outstanding.
module dram_ctrl #(
    parameter int ROW_W   = 11,
    parameter int COL_W   = 10,
    parameter int T_RCD   = 5,
    parameter int T_RP    = 5,
    parameter int T_WR    = 5,
    parameter int T_RD_TO = 15
) (
    input  logic                   dram_clk,
    input  logic                   dram_rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ROW_W+COL_W-1:0] req_addr,
    input  logic [3:0]             req_wstrb,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   DRAM_CSn,
    output logic                   DRAM_RASn,
    output logic                   DRAM_CASn,
    output logic [3:0]             DRAM_WEn,
    output logic [ROW_W-1:0]       DRAM_A,
    output logic [31:0]            DRAM_D,
    input  logic [31:0]            DRAM_Q,
    input  logic                   DRAM_VALID
);

    localparam int AW    = ROW_W + COL_W;
    localparam int T_M1  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_M2  = (T_WR > T_RD_TO) ? T_WR : T_RD_TO;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int TW    = $clog2(T_MAX + 1);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
    localparam bit OPEN_PAGE = 1'b1;
`else
    localparam bit OPEN_PAGE = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ACT, S_WAIT_RCD, S_RD, S_WAIT_RD,
        S_WR, S_WAIT_WR, S_PRE, S_WAIT_RP
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [TW-1:0]      r_tmr;
    logic               w_tmr_ld;
    logic [TW-1:0]      w_tmr_val;
    logic [AW-1:0]      r_addr;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_wdata;
    logic               r_row_open;
    logic [ROW_W-1:0]   r_open_row;
    logic               r_err_pend;
    logic               r_csn, r_rasn, r_casn;
    logic [3:0]         r_wen;
    logic [ROW_W-1:0]   r_a;
    logic [31:0]        r_d;
    logic               r_req_ready, r_rsp_valid, r_rsp_err;
    logic [31:0]        r_rsp_rdata;

    logic               w_acc;
    logic [AW-1:0]      w_addr;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [ROW_W-1:0]   w_row;
    logic [COL_W-1:0]   w_col;
    state_t             w_col_cmd;
    state_t             w_after_acc;
    state_t             w_after_pre;
    logic               w_tmr_end;
    logic               w_tmo;
    logic               w_fin;

    // Commands issued from IDLE must use the request as presented, before it is latched.
    assign w_acc       = (r_state == S_IDLE) && req_valid;
    assign w_addr      = w_acc ? req_addr  : r_addr;
    assign w_wstrb     = w_acc ? req_wstrb : r_wstrb;
    assign w_wdata     = w_acc ? req_wdata : r_wdata;
    assign w_row       = w_addr[AW-1:COL_W];
    assign w_col       = w_addr[COL_W-1:0];
    assign w_col_cmd   = (|w_wstrb) ? S_WR : S_RD;
    assign w_after_acc = OPEN_PAGE ? S_IDLE : S_PRE;
    assign w_after_pre = OPEN_PAGE ? S_ACT  : S_IDLE;
    assign w_tmr_end   = (r_tmr <= TW'(1));
    assign w_tmo       = (r_state == S_WAIT_RD) && !DRAM_VALID && w_tmr_end;
    assign w_fin       = (w_nxt == S_IDLE) && (r_state != S_IDLE) && (r_state != S_INIT);

    always_comb begin
        w_nxt     = r_state;
        w_tmr_ld  = 1'b0;
        w_tmr_val = '0;
        case (r_state)
            S_INIT: w_nxt = S_IDLE;
            S_IDLE: begin
                if (req_valid) begin
                    if (r_row_open && (r_open_row == w_row)) w_nxt = w_col_cmd;
                    else if (r_row_open)                     w_nxt = S_PRE;
                    else                                     w_nxt = S_ACT;
                end
            end
            S_ACT: begin
                if (T_RCD > 1) begin
                    w_nxt     = S_WAIT_RCD;
                    w_tmr_ld  = 1'b1;
                    w_tmr_val = TW'(T_RCD - 1);
                end else begin
                    w_nxt = w_col_cmd;
                end
            end
            S_WAIT_RCD: if (w_tmr_end) w_nxt = w_col_cmd;
            S_RD: begin
                w_nxt     = S_WAIT_RD;
                w_tmr_ld  = 1'b1;
                w_tmr_val = TW'(T_RD_TO - 1);
            end
            S_WAIT_RD: if (DRAM_VALID || w_tmr_end) w_nxt = w_after_acc;
            S_WR: begin
                if (T_WR > 1) begin
                    w_nxt     = S_WAIT_WR;
                    w_tmr_ld  = 1'b1;
                    w_tmr_val = TW'(T_WR - 1);
                end else begin
                    w_nxt = w_after_acc;
                end
            end
            S_WAIT_WR: if (w_tmr_end) w_nxt = w_after_acc;
            S_PRE: begin
                if (T_RP > 1) begin
                    w_nxt     = S_WAIT_RP;
                    w_tmr_ld  = 1'b1;
                    w_tmr_val = TW'(T_RP - 1);
                end else begin
                    w_nxt = w_after_pre;
                end
            end
            S_WAIT_RP: if (w_tmr_end) w_nxt = w_after_pre;
            default: w_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge dram_clk or negedge dram_rstn) begin
        if (!dram_rstn) begin
            r_state     <= S_INIT;
            r_tmr       <= '0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_row_open  <= 1'b0;
            r_open_row  <= '0;
            r_err_pend  <= 1'b0;
            r_csn       <= 1'b1;
            r_rasn      <= 1'b1;
            r_casn      <= 1'b1;
            r_wen       <= 4'hF;
            r_a         <= '0;
            r_d         <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_tmr_ld)               r_tmr <= w_tmr_val;
            else if (r_tmr != '0)       r_tmr <= r_tmr - TW'(1);
            if (w_acc) begin
                r_addr     <= req_addr;
                r_wstrb    <= req_wstrb;
                r_wdata    <= req_wdata;
                r_err_pend <= 1'b0;
            end
            if ((r_state == S_WAIT_RD) && (DRAM_VALID || w_tmr_end)) begin
                r_err_pend <= w_tmo;
                if (DRAM_VALID) r_rsp_rdata <= DRAM_Q;
            end
            // Pins are registered from the next state so each command spans exactly its state cycle.
            r_csn  <= 1'b1;
            r_rasn <= 1'b1;
            r_casn <= 1'b1;
            r_wen  <= 4'hF;
            if (w_nxt != r_state) begin
                case (w_nxt)
                    S_ACT: begin
                        r_csn      <= 1'b0;
                        r_rasn     <= 1'b0;
                        r_a        <= w_row;
                        r_row_open <= 1'b1;
                        r_open_row <= w_row;
                    end
                    S_RD: begin
                        r_csn  <= 1'b0;
                        r_casn <= 1'b0;
                        r_a    <= {{(ROW_W-COL_W){1'b0}}, w_col};
                    end
                    S_WR: begin
                        r_csn  <= 1'b0;
                        r_casn <= 1'b0;
                        r_wen  <= ~w_wstrb;
                        r_a    <= {{(ROW_W-COL_W){1'b0}}, w_col};
                        r_d    <= w_wdata;
                    end
                    S_PRE: begin
                        r_csn      <= 1'b0;
                        r_rasn     <= 1'b0;
                        r_wen      <= 4'h0;
                        r_row_open <= 1'b0;
                    end
                    default: ;
                endcase
            end
            r_req_ready <= (w_nxt == S_IDLE);
            r_rsp_valid <= w_fin;
            r_rsp_err   <= w_fin && ((r_state == S_WAIT_RD) ? w_tmo : r_err_pend);
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign DRAM_CSn  = r_csn;
    assign DRAM_RASn = r_rasn;
    assign DRAM_CASn = r_casn;
    assign DRAM_WEn  = r_wen;
    assign DRAM_A    = r_a;
    assign DRAM_D    = r_d;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a behavioural DRAM pin model (read data returned two cycles after RD).
module tb_dram_ctrl;

    localparam int T_RCD = 5, T_RP = 5, T_WR = 5, T_RD_TO = 15;

    logic        dram_clk, dram_rstn;
    logic        req_valid, req_ready;
    logic [20:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D, DRAM_Q;
    logic        DRAM_VALID;

    dram_ctrl #(.ROW_W(11), .COL_W(10), .T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR), .T_RD_TO(T_RD_TO)) u_dut (
        .dram_clk(dram_clk), .dram_rstn(dram_rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
        .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
        .DRAM_Q(DRAM_Q), .DRAM_VALID(DRAM_VALID)
    );

    initial dram_clk = 1'b0;
    always #5 dram_clk = ~dram_clk;

    int cyc = 0;
    always @(posedge dram_clk) cyc <= cyc + 1;

    // DRAM model state
    logic [31:0] pre_mem [logic [20:0]];
    logic [31:0] wr_mem  [logic [20:0]];
    logic        force_invalid = 1'b0;
    logic [10:0] m_row = '0;
    logic [20:0] rd_key = '0;
    int          rd_dly = 0;
    int          act_cnt = 0, rd_cnt = 0, wr_cnt = 0, pre_cnt = 0, rsp_cnt = 0;
    int          act_cyc = 0, rd_cyc = 0, wr_cyc = 0, pre_cyc = 0;
    logic [10:0] act_a = '0, rd_a = '0, wr_a = '0;
    logic [3:0]  wr_wen = '0;
    logic [31:0] wr_d = '0;

    function automatic logic [31:0] mem_rd(input logic [20:0] k);
        if (wr_mem.exists(k)) return wr_mem[k];
        if (pre_mem.exists(k)) return pre_mem[k];
        return 32'h0;
    endfunction

    initial begin
        DRAM_VALID = 1'b0;
        DRAM_Q     = 32'h0;
    end

    always @(negedge dram_clk) begin
        logic [31:0] tmp;
        logic [20:0] wk;
        DRAM_VALID = 1'b0;
        if (rd_dly > 0) begin
            rd_dly--;
            if (rd_dly == 0 && !force_invalid) begin
                DRAM_VALID = 1'b1;
                DRAM_Q     = mem_rd(rd_key);
            end
        end
        if (!DRAM_CSn) begin
            if (!DRAM_RASn && DRAM_WEn == 4'hF) begin
                act_cnt++; act_cyc = cyc; act_a = DRAM_A; m_row = DRAM_A;
            end else if (!DRAM_RASn) begin
                pre_cnt++; pre_cyc = cyc;
            end else if (!DRAM_CASn && DRAM_WEn == 4'hF) begin
                rd_cnt++; rd_cyc = cyc; rd_a = DRAM_A; rd_key = {m_row, DRAM_A[9:0]}; rd_dly = 2;
            end else if (!DRAM_CASn) begin
                wr_cnt++; wr_cyc = cyc; wr_a = DRAM_A; wr_wen = DRAM_WEn; wr_d = DRAM_D;
                wk  = {m_row, DRAM_A[9:0]};
                tmp = mem_rd(wk);
                for (int b = 0; b < 4; b++)
                    if (!DRAM_WEn[b]) tmp[8*b +: 8] = DRAM_D[8*b +: 8];
                wr_mem[wk] = tmp;
            end
        end
        if (rsp_valid) rsp_cnt++;
    end

    int vec_cnt = 0, miss_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] got_rdata;
    logic        got_err, got_tmo;
    int          got_cyc, ready_hi;

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 100) begin @(negedge dram_clk); n++; end
        chk(tag, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_req(input string tag, input logic [20:0] a, input logic [3:0] s, input logic [31:0] d);
        int n;
        wait_ready(tag);
        req_addr = a; req_wstrb = s; req_wdata = d; req_valid = 1'b1;
        @(negedge dram_clk);
        req_valid = 1'b0; req_wstrb = 4'h0;
        n = 0; ready_hi = 0;
        while (!rsp_valid && n < 200) begin
            if (req_ready) ready_hi++;
            @(negedge dram_clk);
            n++;
        end
        got_tmo = !rsp_valid; got_rdata = rsp_rdata; got_err = rsp_err; got_cyc = cyc;
        @(negedge dram_clk);
    endtask

    int s_act, s_rd, s_pre, s_rsp;
    logic [31:0] prev_rdata;

    initial begin
        dram_rstn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wstrb = '0; req_wdata = '0;
        pre_mem[21'h004000] = 32'hDEADBEEF;
        pre_mem[21'h004001] = 32'hFFFFFFFF;
        pre_mem[21'h004002] = 32'hA5A50002;
        pre_mem[21'h004003] = 32'hA5A50003;
        pre_mem[21'h008000] = 32'h0BADF00D;
        repeat (3) @(negedge dram_clk);
        chk("rst_csn",   {31'h0, DRAM_CSn},  32'h1);
        chk("rst_rasn",  {31'h0, DRAM_RASn}, 32'h1);
        chk("rst_casn",  {31'h0, DRAM_CASn}, 32'h1);
        chk("rst_wen",   {28'h0, DRAM_WEn},  32'hF);
        chk("rst_a",     {21'h0, DRAM_A},    32'h0);
        chk("rst_d",     DRAM_D,             32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_rspv",  {31'h0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata,          32'h0);
        chk("rst_err",   {31'h0, rsp_err},   32'h0);
        dram_rstn = 1'b1;

        // first read, cold row
        do_req("rd0", 21'h004000, 4'h0, 32'h0);
        chk("rd0_tmo",   {31'h0, got_tmo}, 32'h0);
        chk("rd0_data",  got_rdata, 32'hDEADBEEF);
        chk("rd0_err",   {31'h0, got_err}, 32'h0);
        chk("rd0_acta",  {21'h0, act_a}, 32'h010);
        chk("rd0_rda",   {21'h0, rd_a},  32'h000);
        chk("rd0_trcd",  rd_cyc - act_cyc, T_RCD);
        chk("rd0_nrsp",  rsp_cnt, 1);
`ifndef DRAM_CTRL_OPEN_PAGE_EN
        chk("rd0_trp",   got_cyc - pre_cyc, T_RP);
`endif

        // partial write then readback
        do_req("wr1", 21'h004001, 4'b0101, 32'h12345678);
        chk("wr1_err",   {31'h0, got_err}, 32'h0);
        chk("wr1_wen",   {28'h0, wr_wen}, 32'hA);
        chk("wr1_a",     {21'h0, wr_a},   32'h001);
        chk("wr1_d",     wr_d, 32'h12345678);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        chk("wr1_twr",   got_cyc - wr_cyc, T_WR);
`else
        chk("wr1_twr",   pre_cyc - wr_cyc, T_WR);
`endif
        do_req("rb1", 21'h004001, 4'h0, 32'h0);
        chk("rb1_data",  got_rdata, 32'hFF34FF78);

        // two reads in one row, then a row change
        s_act = act_cnt; s_rd = rd_cnt; s_pre = pre_cnt;
        do_req("rd2", 21'h004002, 4'h0, 32'h0);
        chk("rd2_data",  got_rdata, 32'hA5A50002);
        chk("rd2_rdyhi", ready_hi, 0);
        do_req("rd3", 21'h004003, 4'h0, 32'h0);
        chk("rd3_data",  got_rdata, 32'hA5A50003);
        chk("rd3_rdyhi", ready_hi, 0);
        chk("rd23_nrd",  rd_cnt - s_rd, 2);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        chk("rd23_nact", act_cnt - s_act, 0);
        chk("rd23_npre", pre_cnt - s_pre, 0);
`else
        chk("rd23_nact", act_cnt - s_act, 2);
        chk("rd23_npre", pre_cnt - s_pre, 2);
`endif
        s_pre = pre_cnt;
        do_req("rd4", 21'h008000, 4'h0, 32'h0);
        chk("rd4_data",  got_rdata, 32'h0BADF00D);
        chk("rd4_acta",  {21'h0, act_a}, 32'h020);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        chk("rd4_npre",  pre_cnt - s_pre, 1);
        chk("rd4_trp",   act_cyc - pre_cyc, T_RP);
`endif

        // read timeout
        prev_rdata = got_rdata;
        force_invalid = 1'b1;
        do_req("to5", 21'h004004, 4'h0, 32'h0);
        force_invalid = 1'b0;
        chk("to5_err",   {31'h0, got_err}, 32'h1);
        chk("to5_data",  got_rdata, prev_rdata);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        chk("to5_lat",   got_cyc - rd_cyc, T_RD_TO);
`else
        chk("to5_pre",   pre_cyc - rd_cyc, T_RD_TO);
        chk("to5_lat",   got_cyc - rd_cyc, T_RD_TO + T_RP);
`endif
        do_req("rd6", 21'h004000, 4'h0, 32'h0);
        chk("rd6_err",   {31'h0, got_err}, 32'h0);
        chk("rd6_data",  got_rdata, 32'hDEADBEEF);

        // reset in WAIT_RCD drops the request
        wait_ready("rst7_rdy");
        s_rsp = rsp_cnt;
        req_addr = 21'h008001; req_wstrb = 4'h0; req_valid = 1'b1;
        @(negedge dram_clk);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (!(!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) && n < 50) begin
                @(negedge dram_clk); n++;
            end
        end
        @(negedge dram_clk);
        chk("rst7_ahold", {21'h0, DRAM_A}, 32'h020);
        dram_rstn = 1'b0;
        #1;
        chk("rst7_csn",   {31'h0, DRAM_CSn},  32'h1);
        chk("rst7_rasn",  {31'h0, DRAM_RASn}, 32'h1);
        chk("rst7_casn",  {31'h0, DRAM_CASn}, 32'h1);
        chk("rst7_wen",   {28'h0, DRAM_WEn},  32'hF);
        chk("rst7_a",     {21'h0, DRAM_A},    32'h0);
        chk("rst7_ready", {31'h0, req_ready}, 32'h0);
        repeat (2) @(negedge dram_clk);
        dram_rstn = 1'b1;
        @(negedge dram_clk);
        s_act = act_cnt;
        do_req("rd8", 21'h008000, 4'h0, 32'h0);
        chk("rd8_data",  got_rdata, 32'h0BADF00D);
        chk("rd8_nact",  act_cnt - s_act, 1);
        chk("rd8_acta",  {21'h0, act_a}, 32'h020);
        chk("rd8_nrsp",  rsp_cnt - s_rsp, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Single-port controller that sequences the off-chip DRAM pins: CSn, WEn[3:0], RASn, CASn, A[10:0], D, Q, VALID.
- Accepts one word request at a time on a valid/ready interface from the DRAM-side AXI slave wrapper.
- Performs row activate, column read/write and precharge with parameterised timing.
- Lives in the dram_clk domain between the AXI DRAM slave and the top-level DRAM pins.

Parameters:
- ROW_W, 11, row address bits (driven on A[10:0] at activate)
- COL_W, 10, column address bits (driven on A[9:0] at read/write, A[10]=0)
- T_RCD, 5, cycles from activate to first column command (min 1)
- T_RP, 5, cycles from precharge to next activate (min 1)
- T_WR, 5, cycles from write command to precharge/next command (min 1)
- T_RD_TO, 15, cycles waiting for VALID before read timeout

Ports:
- dram_clk  in  1  controller clock
- dram_rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when valid&ready
- req_addr  in  21  word address: {row[20:10], col[9:0]}
- req_wstrb  in  4  byte write enables; 4'h0 = read
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse: read data valid or write done
- rsp_rdata  out  32  read data (held until next read completes)
- rsp_err  out  1  read timeout flag, qualified by rsp_valid
- DRAM_CSn  out  1  chip select, active low
- DRAM_RASn  out  1  row strobe, active low
- DRAM_CASn  out  1  column strobe, active low
- DRAM_WEn  out  4  per-byte write enable, active low
- DRAM_A  out  11  row/column address
- DRAM_D  out  32  write data
- DRAM_Q  in  32  read data
- DRAM_VALID  in  1  read data valid

Behaviour:
- Reset values:
  - CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - No row open; state INIT.
- All DRAM pin outputs are registered. Commands are one cycle wide; between commands CSn=1, RASn=1, CASn=1, WEn=F.
- Command encodings (CSn,RASn,CASn,WEn):
  - ACT = 0,0,1,F with A=row.
  - RD = 0,1,0,F with A={0,col}.
  - WR = 0,1,0,~wstrb with A={0,col} and D=wdata.
  - PRE = 0,0,1,0.
- States:
  - INIT: one cycle after reset deassert → IDLE.
  - IDLE: req_ready=1. On handshake, latch addr/wstrb/wdata and drop req_ready.
    - Row open and hit → RD/WR.
    - Row open and miss → PRE.
    - No row open → ACT.
  - ACT: issue ACT, record open row → WAIT_RCD.
  - WAIT_RCD: count T_RCD-1 cycles → RD or WR.
  - RD: issue RD → WAIT_RD.
  - WAIT_RD:
    - First cycle with VALID=1: capture Q into rsp_rdata, pulse rsp_valid with rsp_err=0 → IDLE.
    - VALID absent T_RD_TO cycles after RD: pulse rsp_valid with rsp_err=1, rsp_rdata unchanged → IDLE.
  - WR: issue WR → WAIT_WR.
  - WAIT_WR: count T_WR-1 cycles, pulse rsp_valid → IDLE.
  - PRE: issue PRE, clear open-row flag → WAIT_RP.
  - WAIT_RP: count T_RP-1 cycles → ACT.
- Exactly one outstanding request; req_ready is 1 only in IDLE.
- req_wstrb=4'h0 is a read. Any non-zero strobe is a write and touches only the enabled bytes.
- rsp_valid pulses exactly once per accepted request, on the cycle the FSM returns to IDLE. The next request can be accepted the following cycle.
- Timer is a single down-counter sized for max(T_RCD,T_RP,T_WR,T_RD_TO). It reloads on each state entry and does not wrap.
- Reset mid-operation: all outputs return to reset values immediately. The open-row flag clears and the pending request is dropped with no rsp_valid.
- VALID outside WAIT_RD is ignored.

Optional Feature:
- Macro DRAM_CTRL_OPEN_PAGE_EN.
- Defined: open-page policy as above; the row stays open after each access, and a same-row hit skips ACT/T_RCD.
- Undefined: closed-page policy. Every access runs ACT → RD/WR → wait → PRE → T_RP before returning to IDLE; rsp_valid is asserted on the IDLE-entry cycle after T_RP.

Test Plan:
- Reset release, then read addr 21'h004000 with DRAM model preloaded 32'hDEADBEEF → ACT A=11'h010, RD A=11'h000 after T_RCD, rsp_rdata=DEADBEEF, rsp_err=0.
- Write 32'h12345678 strobe 4'b0101 to 21'h004001, then read it back over old data 32'hFFFFFFFF → WEn=4'b1010 on WR, readback 32'hFF34FF78.
- OPEN_PAGE_EN: two reads 21'h004002 then 21'h004003 → second request issues no ACT, 1 RD only. Then read 21'h008000 → PRE, T_RP wait, ACT A=11'h020.
- Without OPEN_PAGE_EN: two same-row reads → each shows ACT, RD, PRE; req_ready low until T_RP expires.
- Read with DRAM VALID forced low → rsp_valid with rsp_err=1 exactly T_RD_TO cycles after RD; next request accepted normally.
- Assert dram_rstn low during WAIT_RCD → pins immediately CSn=1, RASn=1, CASn=1, WEn=F, req_ready=0. After release, a new read to the same row issues ACT again and no rsp_valid is produced for the dropped request.
